// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage: pipeline control bundles,
// the registered IF output and the fetch-queue entry layout.
package fetch_stage_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    typedef struct packed {
        logic [XLEN-1:0] PC;
        logic            valid;
    } if_stage_output_t;

    typedef struct packed {
        logic            flushEn;
        logic [XLEN-1:0] redirectPC;
    } flush_req_t;

    typedef struct packed {
        logic stallEn;
        logic start;
    } stall_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
        logic            filled;
    } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order fetch queue: entries are allocated at request time, filled in order
// by responses, and popped from the head once filled.
module fetch_queue
    import fetch_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned width = XLEN,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_en_i,
    input  logic             clear_i,
    input  logic             alloc_i,
    input  logic [width-1:0] alloc_pc_i,
    input  logic             fill_i,
    input  logic [width-1:0] fill_instr_i,
    input  logic             pop_i,
    output fq_entry_t        head_o,
    output logic [CNT_W-1:0] count_o,
    output logic [CNT_W-1:0] unfilled_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] PTR_ONE = CNT_W'(1);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [CNT_W-1:0] head_q, head_d;
    logic [CNT_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0] tail_q, tail_d;
    logic [DEPTH-1:0] filled_q, filled_d;

    logic [width-1:0] pc_mem    [DEPTH];
    logic [width-1:0] instr_mem [DEPTH];

    logic [IDX_W-1:0] head_idx, fill_idx, tail_idx;
    logic             do_fill, do_pop;

    assign head_idx   = head_q[IDX_W-1:0];
    assign fill_idx   = fill_q[IDX_W-1:0];
    assign tail_idx   = tail_q[IDX_W-1:0];
    assign count_o    = tail_q - head_q;
    assign unfilled_o = tail_q - fill_q;

    assign do_fill = fill_i && (unfilled_o != '0);
    assign do_pop  = pop_i && filled_q[head_idx];

    always_comb begin
        head_o.pc     = pc_mem[head_idx];
        head_o.instr  = instr_mem[head_idx];
        head_o.filled = filled_q[head_idx];
    end

    always_comb begin
        // NOTE: every next-state variable gets a default first so no path leaves it unassigned (no latch).
        head_d   = head_q;
        fill_d   = fill_q;
        tail_d   = tail_q;
        filled_d = filled_q;
        if (clear_i) begin
            head_d   = '0;
            fill_d   = '0;
            tail_d   = '0;
            filled_d = '0;
        end else begin
            if (alloc_i) begin
                tail_d = tail_q + PTR_ONE;
            end
            if (do_fill) begin
                filled_d[fill_idx] = 1'b1;
                fill_d             = fill_q + PTR_ONE;
            end
            // A popped head is always filled, so it never shares a slot with the fill pointer.
            if (do_pop) begin
                filled_d[head_idx] = 1'b0;
                head_d             = head_q + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            head_q   <= '0;
            fill_q   <= '0;
            tail_q   <= '0;
            filled_q <= '0;
        end else if (clk_en_i) begin
            head_q   <= head_d;
            fill_q   <= fill_d;
            tail_q   <= tail_d;
            filled_q <= filled_d;
        end
    end

    // NOTE: payload storage is not reset; the filled flags alone decide whether an entry is meaningful.
    always_ff @(posedge clk) begin
        if (clk_en_i && alloc_i && !clear_i) begin
            pc_mem[tail_idx] <= alloc_pc_i;
        end
        if (clk_en_i && do_fill && !clear_i) begin
            instr_mem[fill_idx] <= fill_instr_i;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, gates word requests to memory,
// discards stale responses after a redirect and registers the output to decode.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned       width        = XLEN,
    parameter logic [width-1:0]  RESET_VECTOR = '0,
    parameter int unsigned       DEPTH        = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clkEn,
    input  flush_req_t       flush,
    input  stall_t           stall,
    output logic             imemReqValid,
    input  logic             imemReqReady,
    output logic [width-1:0] imemReqAddr,
    input  logic             imemRespValid,
    input  logic [width-1:0] imemRespData,
    output if_stage_output_t stageOutput,
    output logic [width-1:0] instruction
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [width-1:0] fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    if_stage_output_t stage_out_q, stage_out_d;
    logic [width-1:0] instr_q, instr_d;

    fq_entry_t        head;
    logic [CNT_W-1:0] q_count, q_unfilled, pending;
    logic             flush_now, resp_now, dropping, req_fire, fill, advance, pop;
    logic             unused_bits;

    assign flush_now = clkEn && flush.flushEn;
    assign resp_now  = clkEn && imemRespValid;
    assign dropping  = (drop_cnt_q != '0);
    assign req_fire  = imemReqValid && imemReqReady;
    assign fill      = resp_now && !dropping && !flush.flushEn;
    assign advance   = clkEn && !stall.stallEn && !flush.flushEn;
    assign pop       = advance && head.filled;
    assign pending   = q_unfilled + drop_cnt_q;

    // New requests wait until every stale response has drained, so none can alias.
    assign imemReqValid = rst && clkEn && !flush.flushEn && !dropping
                          && (q_count < CNT_W'(DEPTH));
    assign imemReqAddr  = fetch_pc_q;
    assign stageOutput  = stage_out_q;
    assign instruction  = instr_q;
    assign unused_bits  = ^{stall.start, flush.redirectPC[1:0]};

    fetch_queue #(
        .DEPTH (DEPTH),
        .width (width)
    ) u_queue (
        .clk          (clk),
        .rst_n        (rst),
        .clk_en_i     (clkEn),
        .clear_i      (flush_now),
        .alloc_i      (req_fire),
        .alloc_pc_i   (fetch_pc_q),
        .fill_i       (fill),
        .fill_instr_i (imemRespData),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (q_count),
        .unfilled_o   (q_unfilled)
    );

    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        drop_cnt_d  = drop_cnt_q;
        stage_out_d = stage_out_q;
        instr_d     = instr_q;

        if (flush_now) begin
            fetch_pc_d  = {flush.redirectPC[width-1:2], 2'b00};
            // A response landing in the flush cycle is itself one of the stale ones.
            drop_cnt_d  = (resp_now && pending != '0) ? pending - CNT_W'(1) : pending;
            stage_out_d = '0;
            instr_d     = '0;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + width'(INSTR_BYTES);
            end
            if (resp_now && dropping) begin
                drop_cnt_d = drop_cnt_q - CNT_W'(1);
            end
            if (advance) begin
                if (head.filled) begin
                    stage_out_d.PC    = head.pc;
                    stage_out_d.valid = 1'b1;
                    instr_d           = head.instr;
                end else begin
                    stage_out_d.valid = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q  <= RESET_VECTOR;
            drop_cnt_q  <= '0;
            stage_out_q <= '0;
            instr_q     <= '0;
        end else if (clkEn) begin
            fetch_pc_q  <= fetch_pc_d;
            drop_cnt_q  <= drop_cnt_d;
            stage_out_q <= stage_out_d;
            instr_q     <= instr_d;
        end
    end

    a_no_resp_when_gated: assert property (
        @(posedge clk) disable iff (!rst) !(imemRespValid && !clkEn)
    );

    a_no_orphan_resp: assert property (
        @(posedge clk) disable iff (!rst) (resp_now && !dropping) |-> (q_unfilled != '0)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a fixed-latency in-order memory model
// whose response data is addr ^ 32'hA5A5_0000.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clkEn = 1'b0;
    flush_req_t       flush = '0;
    stall_t           stall = '0;
    logic             imemReqValid;
    logic             imemReqReady = 1'b0;
    logic [31:0]      imemReqAddr;
    logic             imemRespValid = 1'b0;
    logic [31:0]      imemRespData = '0;
    if_stage_output_t stageOutput;
    logic [31:0]      instruction;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    pend_t       pend[$];
    logic [31:0] acc_log[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          n;
    logic        req_v_s;
    logic [31:0] req_a_s;

    fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .clkEn         (clkEn),
        .flush         (flush),
        .stall         (stall),
        .imemReqValid  (imemReqValid),
        .imemReqReady  (imemReqReady),
        .imemReqAddr   (imemReqAddr),
        .imemRespValid (imemRespValid),
        .imemRespData  (imemRespData),
        .stageOutput   (stageOutput),
        .instruction   (instruction)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] so(input logic [31:0] pc, input logic v);
        return {31'b0, pc, v};
    endfunction

    // One clock cycle: drive this cycle's response, sample the request at the
    // falling edge, then retire the edge in the memory model at posedge+1.
    task automatic step();
        logic acc, cons;
        if (rst && clkEn && pend.size() > 0 && pend[0].due <= cyc) begin
            imemRespValid = 1'b1;
            imemRespData  = pend[0].addr ^ 32'hA5A5_0000;
        end else begin
            imemRespValid = 1'b0;
            imemRespData  = '0;
        end
        @(negedge clk);
        req_v_s = imemReqValid;
        req_a_s = imemReqAddr;
        acc     = imemReqValid && imemReqReady;
        cons    = rst && clkEn && imemRespValid;
        @(posedge clk);
        #1;
        cyc++;
        if (cons) void'(pend.pop_front());
        if (acc) begin
            pend.push_back('{addr: req_a_s, due: cyc + lat - 1});
            acc_log.push_back(req_a_s);
        end
    endtask

    task automatic wait_valid(input string tag, input int max_cycles, output int steps);
        steps = 0;
        do begin
            step();
            steps++;
        end while (!stageOutput.valid && steps < max_cycles);
        check({tag, "_seen"}, 64'(stageOutput.valid), 64'(1));
    endtask

    task automatic do_reset();
        rst = 1'b0;
        pend.delete();
        acc_log.delete();
        imemRespValid = 1'b0;
        imemRespData  = '0;
        flush         = '0;
        stall         = '0;
        clkEn         = 1'b1;
        imemReqReady  = 1'b1;
        @(negedge clk);
        check("rst_out",   64'(stageOutput), 64'(0));
        check("rst_instr", 64'(instruction), 64'(0));
        check("rst_reqv",  64'(imemReqValid), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        // Test 1: reset release, streaming with a 1-cycle memory.
        lat = 1;
        do_reset();
        step(); check("t1_req0", {req_v_s, req_a_s}, {1'b1, 32'h0});
        step(); check("t1_req1", {req_v_s, req_a_s}, {1'b1, 32'h4});
        step(); check("t1_req2", {req_v_s, req_a_s}, {1'b0, 32'h8});
        check("t1_out0",   64'(stageOutput), so(32'h0, 1'b1));
        check("t1_instr0", 64'(instruction), 64'(32'hA5A5_0000));
        step(); check("t1_req3", {req_v_s, req_a_s}, {1'b1, 32'h8});
        check("t1_out1",   64'(stageOutput), so(32'h4, 1'b1));
        check("t1_instr1", 64'(instruction), 64'(32'hA5A5_0004));
        step(); check("t1_bubble", 64'(stageOutput), so(32'h4, 1'b0));
        step(); check("t1_out2",   64'(stageOutput), so(32'h8, 1'b1));
        check("t1_instr2", 64'(instruction), 64'(32'hA5A5_0008));

        // Test 3: stall while streaming; at most two requests outstanding.
        stall.stallEn = 1'b1;
        step(); check("t3_req", {req_v_s, req_a_s}, {1'b1, 32'h10});
        check("t3_hold0", 64'(stageOutput), so(32'h8, 1'b1));
        for (int i = 1; i < 4; i++) begin
            step();
            check($sformatf("t3_full%0d", i), 64'(req_v_s), 64'(0));
            check($sformatf("t3_hold%0d", i), 64'(stageOutput), so(32'h8, 1'b1));
        end
        check("t3_instr_hold", 64'(instruction), 64'(32'hA5A5_0008));
        stall.stallEn = 1'b0;
        step(); check("t3_outC",  64'(stageOutput), so(32'hC, 1'b1));
        step(); check("t3_out10", 64'(stageOutput), so(32'h10, 1'b1));
        check("t3_instr10", 64'(instruction), 64'(32'hA5A5_0010));

        // Test 2: request back-pressure holds address and valid.
        do_reset();
        imemReqReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("t2_req%0d", i), {req_v_s, req_a_s}, {1'b1, 32'h0});
            check($sformatf("t2_out%0d", i), 64'(stageOutput), 64'(0));
        end
        imemReqReady = 1'b1;
        step(); check("t2_accept", 64'(acc_log.size()), 64'(1));

        // Test 4: redirect with two requests outstanding, 3-cycle memory.
        lat = 3;
        do_reset();
        step();
        step();
        acc_log.delete();
        flush = '{flushEn: 1'b1, redirectPC: 32'h103};
        step(); check("t4_flush_noreq", 64'(req_v_s), 64'(0));
        check("t4_flush_out", 64'(stageOutput), 64'(0));
        flush = '0;
        wait_valid("t4", 20, n);
        check("t4_latency", 64'(n), 64'(7));
        check("t4_first_req", (acc_log.size() > 0) ? 64'(acc_log[0]) : 64'hDEAD, 64'(32'h100));
        check("t4_out", 64'(stageOutput), so(32'h100, 1'b1));
        check("t4_instr", 64'(instruction), 64'(32'hA5A5_0100));

        // Test 5: flush coinciding with a response while stalled.
        lat = 2;
        do_reset();
        for (int i = 0; i < 6; i++) step();
        check("t5_pre_out", 64'(stageOutput), so(32'h4, 1'b0));
        check("t5_pre_instr", 64'(instruction), 64'(32'hA5A5_0004));
        flush = '{flushEn: 1'b1, redirectPC: 32'h200};
        stall.stallEn = 1'b1;
        step(); check("t5_out_zero", 64'(stageOutput), 64'(0));
        check("t5_instr_zero", 64'(instruction), 64'(0));
        check("t5_flush_noreq", 64'(req_v_s), 64'(0));
        flush = '0;
        stall.stallEn = 1'b0;
        step(); check("t5_drop_one", 64'(req_v_s), 64'(0));
        step(); check("t5_resume", {req_v_s, req_a_s}, {1'b1, 32'h200});
        wait_valid("t5", 10, n);
        check("t5_out", 64'(stageOutput), so(32'h200, 1'b1));

        // Test 6: clock-enable freeze followed by an asynchronous reset pulse.
        lat = 1;
        do_reset();
        for (int i = 0; i < 4; i++) step();
        check("t6_pre", 64'(stageOutput), so(32'h4, 1'b1));
        clkEn = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("t6_noreq%0d", i), 64'(req_v_s), 64'(0));
            check($sformatf("t6_hold%0d", i), 64'(stageOutput), so(32'h4, 1'b1));
        end
        check("t6_instr_hold", 64'(instruction), 64'(32'hA5A5_0004));
        #2;
        rst = 1'b0;
        pend.delete();
        imemRespValid = 1'b0;
        imemRespData  = '0;
        clkEn = 1'b1;
        #1;
        check("t6_async_out",   64'(stageOutput), 64'(0));
        check("t6_async_instr", 64'(instruction), 64'(0));
        check("t6_async_reqv",  64'(imemReqValid), 64'(0));
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(); check("t6_restart", {req_v_s, req_a_s}, {1'b1, 32'h0});
        wait_valid("t6", 10, n);
        check("t6_out", 64'(stageOutput), so(32'h0, 1'b1));
        check("t6_instr", 64'(instruction), 64'(32'hA5A5_0000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
